// File: rtl/vga_disp_if.sv
// Pixel-source and display-side signals of the VGA display controller.
// The controller takes the master view; the pixel source and sink take the slave view.
interface vga_disp_if #(
    parameter int CW = 11
);
    logic          en;
    logic [1:0]    pix_fmt;
    logic [23:0]   pix_data;
    logic          pix_data_req;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          de;
    logic          hsync;
    logic          vsync;
    logic          frame_start;
    logic          line_start;
    logic [7:0]    vga_r;
    logic [7:0]    vga_g;
    logic [7:0]    vga_b;

    modport master (
        input  en, pix_fmt, pix_data,
        output pix_data_req, pix_x, pix_y, de, hsync, vsync,
               frame_start, line_start, vga_r, vga_g, vga_b
    );

    modport slave (
        output en, pix_fmt, pix_data,
        input  pix_data_req, pix_x, pix_y, de, hsync, vsync,
               frame_start, line_start, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_disp_ctrl.sv
// VGA raster timing generator with pixel fetch strobe and pixel-format expansion,
// all in the vga_clk domain.
module vga_disp_ctrl #(
    parameter int   H_FRONT  = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   H_ACT    = 640,
    parameter int   V_FRONT  = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter int   V_ACT    = 480,
    parameter int   CW       = 11,
    parameter int   REQ_LEAD = 1,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    vga_disp_if.master bus
);
    // state | meaning
    // IDLE  | counters parked at (0,0), outputs inactive, waiting for en
    // RUN   | scanning the raster; en is looked at only on the last pixel of a frame
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL = H_BLANK + H_ACT;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int V_TOTAL = V_BLANK + V_ACT;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic [1:0]    fmt_q, fmt_d;

    logic          hsync_q, vsync_q, de_q, pix_data_req_q;
    logic          frame_start_q, line_start_q;
    logic [CW-1:0] pix_x_q, pix_y_q;

    logic          run, h_last, v_last, at_origin;
    logic          h_sync_rgn, v_sync_rgn, h_act, v_act, req_rgn, de_d;
    logic [CW:0]   h_lead;
    logic [2:0]    bar_k;
    logic [7:0]    vga_r_c, vga_g_c, vga_b_c;

    assign run       = (state_q == ST_RUN);
    assign h_last    = (h_q == CW'(H_TOTAL - 1));
    assign v_last    = (v_q == CW'(V_TOTAL - 1));
    assign at_origin = (h_q == '0) && (v_q == '0);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        fmt_d   = fmt_q;
        case (state_q)
            ST_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (bus.en) begin
                    state_d = ST_RUN;
                    fmt_d   = bus.pix_fmt;
                end
            end
            default: begin
                if (at_origin) begin
                    fmt_d = bus.pix_fmt;
                end
                if (h_last) begin
                    h_d = '0;
                    v_d = v_last ? '0 : v_q + CNT_ONE;
                    if (v_last && !bus.en) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    h_d = h_q + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            fmt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            fmt_q   <= fmt_d;
        end
    end

    assign h_sync_rgn = (h_q >= CW'(H_FRONT)) && (h_q < CW'(H_FRONT + H_SYNC));
    assign v_sync_rgn = (v_q >= CW'(V_FRONT)) && (v_q < CW'(V_FRONT + V_SYNC));
    assign h_act      = (h_q >= CW'(H_BLANK));
    assign v_act      = (v_q >= CW'(V_BLANK));
    assign de_d       = run && h_act && v_act;

    // One extra bit so the look-ahead cannot wrap past the end of the line.
    assign h_lead  = {1'b0, h_q} + (CW+1)'(REQ_LEAD);
    assign req_rgn = (h_lead >= (CW+1)'(H_BLANK)) && (h_lead < (CW+1)'(H_TOTAL));

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hsync_q        <= ~HS_POL;
            vsync_q        <= ~VS_POL;
            de_q           <= 1'b0;
            pix_data_req_q <= 1'b0;
            frame_start_q  <= 1'b0;
            line_start_q   <= 1'b0;
            pix_x_q        <= '0;
            pix_y_q        <= '0;
        end else begin
            hsync_q        <= (run && h_sync_rgn) ? HS_POL : ~HS_POL;
            vsync_q        <= (run && v_sync_rgn) ? VS_POL : ~VS_POL;
            de_q           <= de_d;
            pix_data_req_q <= run && v_act && req_rgn && (fmt_q != 2'd3);
            frame_start_q  <= run && at_origin;
            line_start_q   <= de_d && !de_q;
            pix_x_q        <= de_d ? h_q - CW'(H_BLANK) : '0;
            pix_y_q        <= de_d ? v_q - CW'(V_BLANK) : '0;
        end
    end

    assign bar_k = 3'(({3'b000, pix_x_q} << 3) / (CW+3)'(H_ACT));

    always_comb begin
        vga_r_c = 8'h00;
        vga_g_c = 8'h00;
        vga_b_c = 8'h00;
        if (de_q) begin
            case (fmt_q)
                2'd0: begin
                    vga_r_c = {bus.pix_data[15:11], bus.pix_data[15:13]};
                    vga_g_c = {bus.pix_data[10:5],  bus.pix_data[10:9]};
                    vga_b_c = {bus.pix_data[4:0],   bus.pix_data[4:2]};
                end
                2'd1: begin
                    vga_r_c = bus.pix_data[23:16];
                    vga_g_c = bus.pix_data[15:8];
                    vga_b_c = bus.pix_data[7:0];
                end
                2'd2: begin
                    vga_r_c = bus.pix_data[7:0];
                    vga_g_c = bus.pix_data[7:0];
                    vga_b_c = bus.pix_data[7:0];
                end
                default: begin
                    vga_r_c = {8{bar_k[2]}};
                    vga_g_c = {8{bar_k[1]}};
                    vga_b_c = {8{bar_k[0]}};
                end
            endcase
        end
    end

    assign bus.hsync        = hsync_q;
    assign bus.vsync        = vsync_q;
    assign bus.de           = de_q;
    assign bus.pix_data_req = pix_data_req_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.line_start   = line_start_q;
    assign bus.pix_x        = pix_x_q;
    assign bus.pix_y        = pix_y_q;
    assign bus.vga_r        = vga_r_c;
    assign bus.vga_g        = vga_g_c;
    assign bus.vga_b        = vga_b_c;
endmodule

// File: tb/tb_vga_disp_ctrl.sv
// Bench for vga_disp_ctrl on a reduced 25x11 raster: pixel scoreboard fed from the
// fetch strobe, plus raster-position checks of every output on every cycle.
`timescale 1ns/1ps
module tb_vga_disp_ctrl;
    localparam int CW    = 6;
    localparam int HT    = 25;          // 2+3+4+16
    localparam int FRAME = 275;         // 25 x 11 lines
    // Hand-derived positions within the reduced raster (output cycles after frame_start).
    localparam int HS_BEG = 2,  HS_END = 5;
    localparam int VS_BEG = 1,  VS_END = 3;
    localparam int HA_BEG = 9,  VA_BEG = 5;
    localparam int RQ_BEG = 6,  RQ_END = 22;

    logic vga_clk = 1'b0;
    logic sys_rst_n;
    int   n_chk = 0;
    int   n_err = 0;
    logic [1:0]  exp_fmt = 2'd0;
    logic        stop_expected = 1'b0;
    logic [23:0] src_q[$];
    logic [23:0] exp_q[$];

    logic [23:0] v565_d [6] = '{24'hA5F800, 24'h000841, 24'h3C07E0, 24'hFF001F, 24'h00FFFF, 24'h128410};
    logic [23:0] v565_e [6] = '{24'hFF0000, 24'h080808, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h848284};
    logic [23:0] v888_d [4] = '{24'h123456, 24'hA5C3E7, 24'h000000, 24'hFFFFFF};
    logic [23:0] vgr_d  [4] = '{24'hFFFF3C, 24'h00AA81, 24'h123400, 24'h0000FF};
    logic [23:0] vgr_e  [4] = '{24'h3C3C3C, 24'h818181, 24'h000000, 24'hFFFFFF};
    logic [23:0] bar_e  [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                                24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

    vga_disp_if #(.CW(CW)) bus ();

    vga_disp_ctrl #(
        .H_FRONT(2), .H_SYNC(3), .H_BACK(4), .H_ACT(16),
        .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .V_ACT(6),
        .CW(CW), .REQ_LEAD(3), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .vga_clk  (vga_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_hsync"}, 32'(bus.hsync), 32'(1));
        chk({tag, "_vsync"}, 32'(bus.vsync), 32'(1));
        chk({tag, "_de"}, 32'(bus.de), 32'(0));
        chk({tag, "_req"}, 32'(bus.pix_data_req), 32'(0));
        chk({tag, "_fs"}, 32'(bus.frame_start), 32'(0));
        chk({tag, "_ls"}, 32'(bus.line_start), 32'(0));
        chk({tag, "_pix_xy"}, 32'({bus.pix_x, bus.pix_y}), 32'(0));
        chk({tag, "_rgb"}, 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(0));
    endtask

    // Pixel source: answers each fetch strobe and queues the colour it should produce.
    initial begin
        int i565, i888, igr;
        logic [23:0] d, e;
        i565 = 0; i888 = 0; igr = 0;
        bus.pix_data = '0;
        forever begin
            @(negedge vga_clk);
            if (!sys_rst_n) begin
                src_q.delete();
            end else begin
                if (bus.frame_start) exp_fmt = bus.pix_fmt;
                if (bus.pix_data_req && exp_fmt != 2'd3) begin
                    case (exp_fmt)
                        2'd0: begin d = v565_d[i565]; e = v565_e[i565]; i565 = (i565 + 1) % 6; end
                        2'd1: begin d = v888_d[i888]; e = v888_d[i888]; i888 = (i888 + 1) % 4; end
                        default: begin d = vgr_d[igr]; e = vgr_e[igr]; igr = (igr + 1) % 4; end
                    endcase
                    src_q.push_back(d);
                    exp_q.push_back(e);
                end
                if (bus.de && exp_fmt != 2'd3 && src_q.size() != 0) bus.pix_data = src_q.pop_front();
                else bus.pix_data = 24'($urandom);
            end
        end
    end

    // Monitor: raster position from the last frame_start, pixel colours from the scoreboard.
    initial begin
        int pos, hp, vp;
        logic trk, idle_seen, de_e;
        logic [23:0] e;
        pos = 0; trk = 1'b0; idle_seen = 1'b0;
        forever begin
            @(negedge vga_clk);
            #1;
            if (!sys_rst_n) begin
                trk = 1'b0;
                idle_seen = 1'b0;
                exp_q.delete();
                chk_idle("reset");
            end else begin
                pos++;
                if (bus.frame_start) begin
                    if (trk && !idle_seen) chk("frame_period", 32'(pos), 32'(FRAME));
                    trk = 1'b1;
                    idle_seen = 1'b0;
                    pos = 0;
                end else if (trk && pos == FRAME) begin
                    if (stop_expected) idle_seen = 1'b1;
                    else chk("frame_start_missing", 32'(bus.frame_start), 32'(1));
                end
                if (!trk || pos >= FRAME) begin
                    chk_idle("idle");
                end else begin
                    hp   = pos % HT;
                    vp   = pos / HT;
                    de_e = (hp >= HA_BEG) && (vp >= VA_BEG);
                    chk("hsync", 32'(bus.hsync), 32'(!(hp >= HS_BEG && hp < HS_END)));
                    chk("vsync", 32'(bus.vsync), 32'(!(vp >= VS_BEG && vp < VS_END)));
                    chk("de", 32'(bus.de), 32'(de_e));
                    chk("pix_data_req", 32'(bus.pix_data_req),
                        32'(vp >= VA_BEG && hp >= RQ_BEG && hp < RQ_END && exp_fmt != 2'd3));
                    chk("line_start", 32'(bus.line_start), 32'(de_e && hp == HA_BEG));
                    chk("pix_x", 32'(bus.pix_x), 32'(de_e ? hp - HA_BEG : 0));
                    chk("pix_y", 32'(bus.pix_y), 32'(de_e ? vp - VA_BEG : 0));
                    if (!de_e) begin
                        chk("rgb_blank", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(0));
                    end else if (exp_fmt == 2'd3) begin
                        chk("rgb_bars", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(bar_e[(hp - HA_BEG) / 2]));
                    end else if (exp_q.size() == 0) begin
                        chk("sb_underflow", 32'(exp_q.size()), 32'(1));
                    end else begin
                        e = exp_q.pop_front();
                        chk("rgb_pixel", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(e));
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge vga_clk);
        #2;
    endtask

    task automatic start_run();
        int n;
        n = 0;
        bus.en = 1'b1;
        do begin
            @(negedge vga_clk);
            #2;
            n++;
        end while (!bus.frame_start && n < 10);
        chk("start_latency", 32'(n), 32'(2));
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge vga_clk);
            #2;
            n++;
        end while (!bus.frame_start && n < 2 * FRAME);
        if (!bus.frame_start) chk("frame_start_timeout", 32'(bus.frame_start), 32'(1));
    endtask

    initial begin
        sys_rst_n   = 1'b1;
        bus.en      = 1'b0;
        bus.pix_fmt = 2'd0;
        #1 sys_rst_n = 1'b0;
        step(3);
        sys_rst_n = 1'b1;
        step(8);

        start_run();                    // frame 1: RGB565
        step(75);
        bus.pix_fmt = 2'd3;             // mid-frame change, takes effect next frame
        wait_fs();                      // frame 2: bars
        step(75);
        bus.pix_fmt = 2'd1;
        wait_fs();                      // frame 3: RGB888
        step(75);
        bus.pix_fmt = 2'd2;
        wait_fs();                      // frame 4: GREY8, en glitch mid-frame
        step(75);
        bus.en = 1'b0;
        step(125);
        bus.en = 1'b1;
        wait_fs();                      // frame 5: en dropped, must finish then park
        step(100);
        bus.en = 1'b0;
        stop_expected = 1'b1;
        step(FRAME - 100 + 60);

        bus.pix_fmt = 2'd0;
        stop_expected = 1'b0;
        start_run();                    // frame 6: reset hits an active pixel
        step(7 * HT + 12);
        sys_rst_n = 1'b0;
        bus.en = 1'b0;
        #1;
        chk_idle("async_reset");
        step(3);
        sys_rst_n = 1'b1;
        step(10);

        bus.pix_fmt = 2'd1;
        start_run();
        wait_fs();
        step(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, wanted completion before %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
